// File: rtl/dmem_dma_pkg.sv
// Shared definitions for the DMEM copy/fill engine: FSM state type, memory geometry and
// command mode encodings.
package dmem_dma_pkg;

  localparam int unsigned MEM_BYTES  = 16384;
  localparam int unsigned WORD_BYTES = 4;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StRd,
    StWr,
    StFin
  } state_e;

endpackage

// File: rtl/dmem_dma_addr_gen.sv
// Word address stepper used for the source and destination streams.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   load       : capture base address and direction
//   desc       : direction for the loaded command (1 = step -4, 0 = step +4)
//   base       : starting byte address
//   advance    : step the current address by one word
//   addr       : current byte address
module dmem_dma_addr_gen
  import dmem_dma_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        desc,
  input  logic [31:0] base,
  input  logic        advance,
  output logic [31:0] addr
);

  logic [31:0] addr_q;
  logic        desc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      desc_q <= 1'b0;
    end else if (load) begin
      addr_q <= base;
      desc_q <= desc;
    end else if (advance) begin
      addr_q <= desc_q ? addr_q - 32'(WORD_BYTES) : addr_q + 32'(WORD_BYTES);
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/dmem_dma.sv
// Bus-master block copy/fill engine for the data memory port.
// Ports:
//   clk, reset                      : clock and synchronous active-high reset
//   start, mode, src_addr, dst_addr : command (accepted only while idle)
//   word_count, fill_value
//   busy, done, error, checksum     : status; checksum sums the words written by the last command
//   MemWrite, memory_address, WD2   : memory request (read data returns on Data same cycle)
//   Data                            : combinational read data from memory
module dmem_dma #(
  parameter int unsigned MEM_BYTES = dmem_dma_pkg::MEM_BYTES,
  parameter int unsigned CNT_W     = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic [31:0]      fill_value,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [31:0]      checksum,
  output logic             MemWrite,
  output logic [31:0]      memory_address,
  output logic [31:0]      WD2,
  input  logic [31:0]      Data
);

  import dmem_dma_pkg::*;

  state_e           state_q, state_d;
  logic             mode_q;
  logic [31:0]      src_q, dst_q, fill_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      hold_q, checksum_q;
  logic             error_q;

  logic [31:0] span, last_off, src_base, dst_base, src_cur, dst_cur;
  logic [32:0] src_end, dst_end;
  logic        cmd_err, desc;

  // Region checks use 33 bits so an end address past 2^32 cannot wrap into range.
  assign span     = 32'({cnt_q, 2'b00});
  assign last_off = 32'({cnt_q - CNT_W'(1), 2'b00});
  assign src_end  = {1'b0, src_q} + {1'b0, span};
  assign dst_end  = {1'b0, dst_q} + {1'b0, span};

  assign cmd_err = (dst_q[1:0] != 2'b00) || (dst_end > 33'(MEM_BYTES)) ||
                   ((mode_q == MODE_COPY) &&
                    ((src_q[1:0] != 2'b00) || (src_end > 33'(MEM_BYTES))));

  // Destination inside the source window: copy from the top down so unread source words
  // are not overwritten first.
  assign desc = (mode_q == MODE_COPY) && (dst_q > src_q) && ({1'b0, dst_q} < src_end);

  assign src_base = desc ? src_q + last_off : src_q;
  assign dst_base = desc ? dst_q + last_off : dst_q;

  dmem_dma_addr_gen u_src_gen (
    .clk    (clk),
    .reset  (reset),
    .load   (state_q == StCheck),
    .desc   (desc),
    .base   (src_base),
    .advance(state_q == StRd),
    .addr   (src_cur)
  );

  dmem_dma_addr_gen u_dst_gen (
    .clk    (clk),
    .reset  (reset),
    .load   (state_q == StCheck),
    .desc   (desc),
    .base   (dst_base),
    .advance(state_q == StWr),
    .addr   (dst_cur)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StCheck;
      StCheck: begin
        if (cmd_err || (cnt_q == '0)) state_d = StFin;
        else if (mode_q == MODE_COPY) state_d = StRd;
        else                          state_d = StWr;
      end
      StRd:    state_d = StWr;
      StWr: begin
        if (cnt_q == CNT_W'(1))       state_d = StFin;
        else if (mode_q == MODE_COPY) state_d = StRd;
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy           = (state_q != StIdle);
    done           = (state_q == StFin);
    MemWrite       = (state_q == StWr);
    memory_address = '0;
    WD2            = '0;
    if (state_q == StRd) begin
      memory_address = src_cur;
    end else if (state_q == StWr) begin
      memory_address = dst_cur;
      WD2            = (mode_q == MODE_COPY) ? hold_q : fill_q;
    end
  end

  assign error    = error_q;
  assign checksum = checksum_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      mode_q     <= MODE_COPY;
      src_q      <= '0;
      dst_q      <= '0;
      fill_q     <= '0;
      cnt_q      <= '0;
      hold_q     <= '0;
      checksum_q <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == StIdle) && start) begin
        mode_q <= mode;
        src_q  <= src_addr;
        dst_q  <= dst_addr;
        fill_q <= fill_value;
        cnt_q  <= word_count;
      end
      if (state_q == StCheck) begin
        error_q    <= cmd_err;
        checksum_q <= '0;
      end
      if (state_q == StRd) hold_q <= Data;
      if (state_q == StWr) begin
        checksum_q <= checksum_q + WD2;
        cnt_q      <= cnt_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dmem_dma.sv
// Self-checking bench for dmem_dma: directed scenarios plus randomized copy/fill commands
// checked against a memmove-style array model of the memory.
module tb_dmem_dma;
  import dmem_dma_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, mode;
  logic [31:0] src_addr, dst_addr, fill_value;
  logic [12:0] word_count;
  logic        busy, done, error, MemWrite;
  logic [31:0] checksum, memory_address, WD2, Data;

  logic [31:0] mem [4096];
  int          n_cmp = 0;
  int          n_mis = 0;
  logic [31:0] addr_log [$];
  logic        we_log [$];

  always #5 clk = ~clk;

  assign Data = mem[memory_address[13:2]];
  always @(posedge clk) if (MemWrite) mem[memory_address[13:2]] <= WD2;

  dmem_dma u_dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .mode          (mode),
    .src_addr      (src_addr),
    .dst_addr      (dst_addr),
    .word_count    (word_count),
    .fill_value    (fill_value),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .checksum      (checksum),
    .MemWrite      (MemWrite),
    .memory_address(memory_address),
    .WD2           (WD2),
    .Data          (Data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one command, log every cycle's request, then compare status and memory to the model.
  // poke > 0 re-asserts start with different inputs in that cycle of the command.
  task automatic run_cmd(input logic m, input logic [31:0] s, input logic [31:0] d, input int n,
                         input logic [31:0] fv, input int poke);
    logic [31:0] model [4096];
    logic [31:0] vals [$];
    logic        exp_err;
    logic [31:0] exp_sum;
    int          exp_lat, c, nw, bad;
    exp_err = (d[1:0] != 2'b00) || (longint'(d) + 4 * n > MEM_BYTES);
    if (m == MODE_COPY)
      exp_err = exp_err || (s[1:0] != 2'b00) || (longint'(s) + 4 * n > MEM_BYTES);
    model   = mem;
    exp_sum = 0;
    if (!exp_err) begin
      // All source words are taken before any write: memmove semantics.
      for (int i = 0; i < n; i++) vals.push_back((m == MODE_FILL) ? fv : mem[(s >> 2) + i]);
      for (int i = 0; i < n; i++) begin
        model[(d >> 2) + i] = vals[i];
        exp_sum += vals[i];
      end
    end
    exp_lat = (exp_err || n == 0) ? 2 : ((m == MODE_FILL) ? 2 + n : 2 + 2 * n);

    @(posedge clk); #1;
    mode = m; src_addr = s; dst_addr = d; word_count = 13'(n); fill_value = fv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 1;
    nw = 0;
    addr_log.delete();
    we_log.delete();
    while (!done && c <= exp_lat + 20) begin
      addr_log.push_back(memory_address);
      we_log.push_back(MemWrite);
      if (MemWrite) nw++;
      if (c == poke) begin
        start = 1'b1; mode = ~m; dst_addr = 32'h300; src_addr = 32'h380;
        word_count = 13'd7; fill_value = ~fv;
      end
      @(posedge clk); #1;
      start = 1'b0;
      c++;
    end
    check("done_latency", c, exp_lat);
    check("error", error, exp_err);
    check("checksum", checksum, exp_sum);
    check("write_count", nw, exp_err ? 0 : n);
    @(posedge clk); #1;
    check("done_pulse", done, 0);
    check("busy_after", busy, 0);
    bad = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== model[i]) bad++;
    check("mem_words_wrong", bad, 0);
  endtask

  initial begin
    logic        m;
    logic [31:0] s, d;
    int          n;

    reset = 1'b1; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
    word_count = '0; fill_value = '0;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_checksum", checksum, 0);
    check("rst_memwrite", MemWrite, 0);
    check("rst_addr", memory_address, 0);
    check("rst_wd2", WD2, 0);
    reset = 1'b0;

    // Fill 4 words at 0x100.
    run_cmd(MODE_FILL, 32'h0, 32'h100, 4, 32'hDEADBEEF, 0);
    for (int i = 0; i < 4; i++) begin
      check("fill_addr", addr_log[1 + i], 32'h100 + 4 * i);
      check("fill_we", we_log[1 + i], 1);
    end
    check("fill_sum", checksum, 32'h7AB6FBBC);

    // Plain copy, ascending, alternating RD/WR.
    mem[0] = 1; mem[1] = 2; mem[2] = 3;
    run_cmd(MODE_COPY, 32'h0, 32'h40, 3, 32'h0, 0);
    check("copy_rd0", addr_log[1], 32'h0);
    check("copy_rd0_we", we_log[1], 0);
    check("copy_wr0", addr_log[2], 32'h40);
    check("copy_rd1", addr_log[3], 32'h4);
    check("copy_wr1", addr_log[4], 32'h44);
    check("copy_m40", mem[16], 1);
    check("copy_m48", mem[18], 3);
    check("copy_sum", checksum, 6);

    // Overlapping copy must run top-down.
    mem[0] = 1; mem[1] = 2; mem[2] = 3; mem[3] = 4;
    run_cmd(MODE_COPY, 32'h0, 32'h4, 4, 32'h0, 0);
    check("ovl_rd0", addr_log[1], 32'hC);
    check("ovl_wr0", addr_log[2], 32'h10);
    for (int i = 0; i < 5; i++) check("ovl_mem", mem[i], (i == 0) ? 1 : i);

    // Rejects and empty command.
    run_cmd(MODE_FILL, 32'h0, 32'h102, 2, 32'h1234, 0);
    check("misalign_err", error, 1);
    run_cmd(MODE_COPY, 32'h3FFC, 32'h0, 2, 32'h0, 0);
    check("range_err", error, 1);
    run_cmd(MODE_COPY, 32'h10, 32'h20, 0, 32'h0, 0);
    check("zero_err", error, 0);
    // Region ending exactly at the top of memory is legal.
    run_cmd(MODE_FILL, 32'h0, 32'h3FF0, 4, 32'h600D0001, 0);

    // start re-strobed mid-copy is ignored.
    run_cmd(MODE_COPY, 32'h80, 32'h200, 5, 32'h0, 3);

    // Reset during WR of word 2 of 4.
    for (int i = 0; i < 4; i++) mem[128 + i] = 32'h5000_0000 + i;
    @(posedge clk); #1;
    mode = MODE_FILL; dst_addr = 32'h200; word_count = 13'd4; fill_value = 32'hA5A5A5A5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_wr1", MemWrite, 1);
    @(posedge clk); #1;
    check("rst_mid_wr2_addr", memory_address, 32'h204);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mid_memwrite", MemWrite, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    repeat (4) @(posedge clk);
    #1;
    check("rst_mid_word3", mem[130], 32'h5000_0002);
    check("rst_mid_word4", mem[131], 32'h5000_0003);

    // Randomized commands over a small window so overlaps are frequent.
    for (int k = 0; k < 40; k++) begin
      m = 1'($urandom_range(1, 0));
      n = $urandom_range(12, 0);
      s = 32'($urandom_range(63, 0) * 4);
      d = 32'($urandom_range(63, 0) * 4);
      if ($urandom_range(9) == 0) d = d | 32'h2;
      if ($urandom_range(9) == 0) s = s | 32'h1;
      if ($urandom_range(9) == 0) s = 32'h4000 - 32'($urandom_range(8, 0) * 4);
      if ($urandom_range(9) == 0) d = 32'h4000 - 32'($urandom_range(8, 0) * 4);
      run_cmd(m, s, d, n, $urandom, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/dmem_dma.md
Name: dmem_dma

Overview:
- Bus-master block copy/fill engine that drives the data-memory port from the initiator side: MemWrite, memory_address, WD2 out; Data in.
- Used by the FPGA verification harness to preload, move or clear DMEM regions without the CPU.
- Moves up to 4096 words per command.
- Returns busy, a done pulse, an error flag and a running checksum.

Parameters:
- MEM_BYTES, 16384, addressable DMEM size in bytes; word-addressed via address bits [13:2].
- CNT_W, 13, width of word_count, so 0..4096 words are representable.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  command strobe, sampled only in IDLE
- mode  in  1  0 = copy, 1 = fill
- src_addr  in  32  byte address of source (copy only)
- dst_addr  in  32  byte address of destination
- word_count  in  CNT_W  number of words to move
- fill_value  in  32  word written in fill mode
- busy  out  1  high while a command is executing
- done  out  1  one-cycle pulse at command completion
- error  out  1  high when the last command was rejected; held until next accepted start
- checksum  out  32  mod-2^32 sum of all words written by the last command
- MemWrite  out  1  memory write enable
- memory_address  out  32  byte address to memory
- WD2  out  32  write data to memory
- Data  in  32  combinational read data from memory

Behaviour:
- Reset: state IDLE.
  - busy=0, done=0, error=0, checksum=0.
  - MemWrite=0, memory_address=0, WD2=0.
  - Reset mid-command aborts at that edge; no further writes are issued.
- States: IDLE, CHECK, RD, WR, FIN.
- IDLE:
  - start=1 latches all command inputs and moves to CHECK.
  - start while not IDLE is ignored.
- CHECK (1 cycle, busy=1):
  - error if dst_addr[1:0]!=0.
  - In copy mode, also error if src_addr[1:0]!=0.
  - error if any used region end (addr + 4*word_count) exceeds MEM_BYTES.
  - On error: set error, go FIN, no memory access.
  - word_count==0: go FIN, no memory access, checksum=0.
  - Otherwise clear checksum and error.
  - Copy mode goes to RD; fill mode goes to WR.
- Direction (copy mode, decided in CHECK):
  - Descending if dst > src and dst < src + 4*word_count; this gives memmove semantics for overlapping regions.
  - Otherwise ascending.
  - Descending starts at base + 4*(word_count-1) and steps by -4; ascending steps by +4.
- RD (copy only):
  - memory_address = current src, MemWrite=0.
  - Data is captured into a hold register at the clock edge, then go WR.
- WR:
  - memory_address = current dst, MemWrite=1.
  - WD2 = hold register in copy mode, fill_value in fill mode.
  - checksum += WD2.
  - Decrement the remaining count.
  - If remaining hits 0, go FIN; otherwise go RD (copy) or stay in WR (fill).
- FIN: done=1 for exactly one cycle, busy=0 afterwards, return to IDLE.
- Outputs outside RD/WR: MemWrite=0, memory_address=0, WD2=0. All outputs are registered, or decoded from registered state only.
- Latency, with start accepted at edge T:
  - CHECK occupies cycle T+1.
  - Copy: 2N cycles of RD/WR.
  - Fill: N cycles of WR.
  - done is high in the cycle after the last WR; after a reject or N=0, done is high in the cycle after CHECK.
- Address arithmetic:
  - 32-bit, word-aligned, no wrap.
  - The range check guarantees addresses stay below MEM_BYTES, so bits [31:14] of memory_address are always 0.

Decomposition:
- Package dmem_dma_pkg holds:
  - the state enum;
  - MEM_BYTES = 16384, WORD_BYTES = 4;
  - MODE_COPY/MODE_FILL constants.
- One natural sub-module is dmem_dma_addr_gen.
  - It loads a base address plus direction and emits the current address.
  - It steps by ±4 on an advance strike.
  - Instantiate it twice, once for src and once for dst.

Test Plan:
- Fill, dst=0x100, N=4, fill_value=0xDEADBEEF -> exactly 4 write cycles at 0x100, 0x104, 0x108, 0x10C; done at T+6; checksum=0x7AB6FBBC; busy=0 afterwards.
- Copy, src=0x0 preloaded 1,2,3, dst=0x40, N=3 -> addresses alternate RD 0x0 / WR 0x40 and so on; RAM[0x40..0x48]=1,2,3; checksum=6; done at T+8.
- Overlap copy, src=0x0 holding 1,2,3,4, dst=0x4, N=4 -> descending order (first RD 0xC, first WR 0x10); final words 0x0..0x10 = 1,1,2,3,4.
- Errors:
  - dst=0x102 -> error=1, done at T+2, no MemWrite.
  - src=0x3FFC, N=2 copy -> error=1.
  - N=0 -> error=0, done at T+2, checksum=0.
- start pulsed again during a copy -> ignored, original command completes unchanged.
- reset asserted during WR of word 2 of 4 -> next cycle MemWrite=0, busy=0, done=0; words 3-4 untouched.
